l2_header_inserter: RTL and testbench

//  TX-side counterpart of the parser's L2 header tracking. Takes header fields plus a

---
 rtl/l2_header_inserter.sv | 225 ++++++++++++++++++++++
 tb/tb_l2_header_inserter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_header_inserter.sv
// l2_header_inserter: prepends dst/src MAC, optional 802.1Q tag and EtherType to a
// 64-bit payload stream with byte-accurate realignment. Optional feature: `VLAN_INSERT_EN.
module l2_header_inserter #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hdr_valid,
    output logic                    hdr_ready,
    input  logic [47:0]             hdr_dst_mac,
    input  logic [47:0]             hdr_src_mac,
    input  logic [15:0]             hdr_ethertype,
`ifdef VLAN_INSERT_EN
    input  logic                    hdr_vlan_en,
    input  logic [15:0]             hdr_vlan_tci,
`endif
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [CNT_WIDTH-1:0]    tx_frame_count
);

    if (DATA_WIDTH != 64) begin : g_width_check
        $error("l2_header_inserter supports DATA_WIDTH=64 only");
    end

    typedef enum logic [2:0] {IDLE, HDR, MIX, PAY, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [143:0]           hdr_q, hdr_d;
    logic                   vlan_q, vlan_d;
    logic                   hdr_idx_q, hdr_idx_d;
    logic [47:0]            resid_q, resid_d;
    logic [7:0]             flush_keep_q, flush_keep_d;
    logic [63:0]            m_tdata_q, m_tdata_d;
    logic [7:0]             m_tkeep_q, m_tkeep_d;
    logic                   m_tlast_q, m_tlast_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   vlan_in;
    logic [15:0]            tci_in;
    logic [143:0]           hdr_in;
    logic                   out_adv;
    logic [3:0]             r_len;
    logic [3:0]             p_len;
    logic [3:0]             in_cnt;
    logic [47:0]            head_lo;
    logic [63:0]            mix_data;
    logic [47:0]            mix_resid;

`ifdef VLAN_INSERT_EN
    assign vlan_in = hdr_vlan_en;
    assign tci_in  = hdr_vlan_tci;
`else
    assign vlan_in = 1'b0;
    assign tci_in  = 16'h0000;
`endif

    // Header as a wire-ordered byte vector: byte n lives at [8n+7:8n].
    function automatic logic [143:0] build_hdr(input logic [47:0] dst, input logic [47:0] src,
                                               input logic [15:0] etype, input logic vlan,
                                               input logic [15:0] tci);
        logic [143:0] h;
        h = '0;
        for (int i = 0; i < 6; i++) begin
            h[8*i +: 8]     = dst[8*(5-i) +: 8];
            h[8*(6+i) +: 8] = src[8*(5-i) +: 8];
        end
        if (vlan) begin
            h[111:96]  = 16'h0081;
            h[127:112] = {tci[7:0], tci[15:8]};
            h[143:128] = {etype[7:0], etype[15:8]};
        end else begin
            h[111:96]  = {etype[7:0], etype[15:8]};
        end
        return h;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (4'(i) < n);
        return m;
    endfunction

    assign hdr_in  = build_hdr(hdr_dst_mac, hdr_src_mac, hdr_ethertype, vlan_in, tci_in);
    assign out_adv = !m_tvalid_q || m_tready;
    assign r_len   = vlan_q ? 4'd2 : 4'd6;
    assign p_len   = 4'd8 - r_len;

    // The mixed beat carries R leading bytes (header tail or residual) then P input bytes.
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < 8; i++) in_cnt = in_cnt + {3'b000, s_tkeep[i]};
        if (state_q == MIX) head_lo = vlan_q ? {32'h0, hdr_q[143:128]} : hdr_q[111:64];
        else                head_lo = resid_q;
        mix_data  = vlan_q ? {s_tdata[47:0], head_lo[15:0]} : {s_tdata[15:0], head_lo[47:0]};
        mix_resid = vlan_q ? {32'h0, s_tdata[63:48]} : s_tdata[63:16];
    end

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        vlan_d       = vlan_q;
        hdr_idx_d    = hdr_idx_q;
        resid_d      = resid_q;
        flush_keep_d = flush_keep_q;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q & ~m_tready;
        cnt_d        = cnt_q + {{(CNT_WIDTH-1){1'b0}}, m_tvalid_q & m_tready & m_tlast_q};
        hdr_ready    = (state_q == IDLE);
        s_tready     = ((state_q == MIX) || (state_q == PAY)) && out_adv;
        case (state_q)
            IDLE: begin
                if (hdr_valid) begin
                    hdr_d     = hdr_in;
                    vlan_d    = vlan_in;
                    hdr_idx_d = 1'b0;
                    state_d   = HDR;
                    // Emit the first header beat straight away when the output is free.
                    if (out_adv) begin
                        m_tdata_d  = hdr_in[63:0];
                        m_tkeep_d  = 8'hFF;
                        m_tlast_d  = 1'b0;
                        m_tvalid_d = 1'b1;
                        hdr_idx_d  = 1'b1;
                        state_d    = vlan_in ? HDR : MIX;
                    end
                end
            end
            HDR: begin
                if (out_adv) begin
                    m_tdata_d  = hdr_idx_q ? hdr_q[127:64] : hdr_q[63:0];
                    m_tkeep_d  = 8'hFF;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    if (hdr_idx_q || !vlan_q) state_d = MIX;
                    else                      hdr_idx_d = 1'b1;
                end
            end
            MIX, PAY: begin
                if (s_tvalid && s_tready) begin
                    m_tdata_d  = mix_data;
                    m_tvalid_d = 1'b1;
                    resid_d    = mix_resid;
                    state_d    = PAY;
                    if (s_tlast && (in_cnt <= p_len)) begin
                        m_tkeep_d = keep_mask(r_len + in_cnt);
                        m_tlast_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        m_tkeep_d = 8'hFF;
                        m_tlast_d = 1'b0;
                        if (s_tlast) begin
                            flush_keep_d = keep_mask(in_cnt - p_len);
                            state_d      = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_adv) begin
                    m_tdata_d  = {16'h0000, resid_q};
                    m_tkeep_d  = flush_keep_q;
                    m_tlast_d  = 1'b1;
                    m_tvalid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            vlan_q       <= 1'b0;
            hdr_idx_q    <= 1'b0;
            resid_q      <= '0;
            flush_keep_q <= '0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            vlan_q       <= vlan_d;
            hdr_idx_q    <= hdr_idx_d;
            resid_q      <= resid_d;
            flush_keep_q <= flush_keep_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign m_tdata        = m_tdata_q;
    assign m_tkeep        = m_tkeep_q;
    assign m_tlast        = m_tlast_q;
    assign m_tvalid       = m_tvalid_q;
    assign tx_frame_count = cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && s_tvalid && s_tready)
            assert (s_tkeep != '0) else $error("l2_header_inserter: empty input beat");
    end
`endif

endmodule

// File: tb/tb_l2_header_inserter.sv
// Testbench for l2_header_inserter: random frames scored against a byte-stream model
// (header bytes + payload bytes chopped into 8-byte beats).
module tb_l2_header_inserter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_dst_mac;
    logic [47:0] hdr_src_mac;
    logic [15:0] hdr_ethertype;
`ifdef VLAN_INSERT_EN
    logic        hdr_vlan_en;
    logic [15:0] hdr_vlan_tci;
`endif
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] tx_frame_count;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_len_q[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    exp_frames = 0;
    int    ready_mode = 0;

    always #5 clk = ~clk;

    l2_header_inserter #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .hdr_dst_mac    (hdr_dst_mac),
        .hdr_src_mac    (hdr_src_mac),
        .hdr_ethertype  (hdr_ethertype),
`ifdef VLAN_INSERT_EN
        .hdr_vlan_en    (hdr_vlan_en),
        .hdr_vlan_tci   (hdr_vlan_tci),
`endif
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .tx_frame_count (tx_frame_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sink readiness: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output scoreboard; a transfer seen at the negedge completes on the next posedge.
    initial begin
        beat_t       b;
        logic [63:0] mask;
        int          acc_bytes;
        int          exp_len;
        acc_bytes = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_bytes = 0;
            end else if (m_tvalid && m_tready) begin
                checkOutput("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    b    = exp_q.pop_front();
                    mask = '0;
                    for (int i = 0; i < 8; i++) if (b.keep[i]) mask[8*i +: 8] = 8'hFF;
                    checkOutput("m_tkeep", 64'(m_tkeep), 64'(b.keep));
                    checkOutput("m_tlast", 64'(m_tlast), 64'(b.last));
                    checkOutput("m_tdata", m_tdata & mask, b.data);
                end
                for (int i = 0; i < 8; i++) if (m_tkeep[i]) acc_bytes++;
                if (m_tlast) begin
                    exp_len = -1;
                    if (exp_len_q.size() != 0) exp_len = exp_len_q.pop_front();
                    checkOutput("frame_bytes", 64'(acc_bytes), 64'(exp_len));
                    acc_bytes = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d beats still expected", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        rst_n     = 1'b0;
        hdr_valid = 1'b0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        exp_q.delete();
        exp_len_q.delete();
        exp_frames = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
        checkOutput("rst_m_tdata", m_tdata, 64'd0);
        checkOutput("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_frame_count", 64'(tx_frame_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("hdr_ready_after_reset", 64'(hdr_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1. abort_after >= 0 stops after that many payload beats.
    task automatic applyStimulus(input logic [47:0] dst, input logic [47:0] src,
                                 input logic [15:0] etype, input logic vlan,
                                 input logic [15:0] tci, input int len,
                                 input bit chk_lat, input int abort_after);
        logic [7:0] fb[$];
        logic [7:0] pl[$];
        beat_t      b;
        logic       got;
        int         guard;
        for (int i = 0; i < 6; i++) fb.push_back(8'(dst >> (40 - 8*i)));
        for (int i = 0; i < 6; i++) fb.push_back(8'(src >> (40 - 8*i)));
        if (vlan) begin
            fb.push_back(8'h81);
            fb.push_back(8'h00);
            fb.push_back(tci[15:8]);
            fb.push_back(tci[7:0]);
        end
        fb.push_back(etype[15:8]);
        fb.push_back(etype[7:0]);
        for (int i = 0; i < len; i++) begin
            pl.push_back(8'($urandom));
            fb.push_back(pl[i]);
        end
        for (int i = 0; i < fb.size(); i += 8) begin
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < fb.size()) begin
                    b.data[8*j +: 8] = fb[i+j];
                    b.keep[j]        = 1'b1;
                end
            end
            b.last = (i + 8 >= fb.size());
            exp_q.push_back(b);
        end
        exp_len_q.push_back(fb.size());
        if (abort_after < 0) exp_frames++;

        hdr_dst_mac   = dst;
        hdr_src_mac   = src;
        hdr_ethertype = etype;
`ifdef VLAN_INSERT_EN
        hdr_vlan_en   = vlan;
        hdr_vlan_tci  = tci;
`endif
        hdr_valid = 1'b1;
        got   = 1'b0;
        guard = 0;
        while (!got && guard < 200) begin
            @(negedge clk);
            got = hdr_ready;
            guard++;
        end
        checkOutput("hdr_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
        if (chk_lat) checkOutput("first_beat_latency", 64'(m_tvalid), 64'd1);
        if (!got) return;

        for (int bi = 0; bi * 8 < len; bi++) begin
            if (abort_after >= 0 && bi >= abort_after) break;
            s_tdata = {$urandom, $urandom};
            s_tkeep = '0;
            for (int j = 0; j < 8; j++) begin
                if (bi * 8 + j < len) begin
                    s_tdata[8*j +: 8] = pl[bi*8 + j];
                    s_tkeep[j]        = 1'b1;
                end
            end
            s_tlast  = (bi * 8 + 8 >= len);
            s_tvalid = 1'b1;
            got   = 1'b0;
            guard = 0;
            while (!got && guard < 200) begin
                @(negedge clk);
                got = s_tready;
                guard++;
            end
            checkOutput("payload_accept", 64'(got), 64'd1);
            @(posedge clk);
            #1;
            if (!got) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drainAndCount();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("tx_frame_count", 64'(tx_frame_count), 64'(exp_frames % 65536));
    endtask

    initial begin
        logic [47:0] d;
        logic [47:0] s;
        logic        v;
        hdr_valid     = 1'b0;
        hdr_dst_mac   = '0;
        hdr_src_mac   = '0;
        hdr_ethertype = '0;
`ifdef VLAN_INSERT_EN
        hdr_vlan_en   = 1'b0;
        hdr_vlan_tci  = '0;
`endif
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        doReset();

        $display("[TB] T1/T2: single-beat payloads");
        applyStimulus(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0, 1, 1'b1, -1);
        applyStimulus(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0, 8, 1'b0, -1);
        drainAndCount();

        $display("[TB] T3: toggling m_tready");
        ready_mode = 1;
        applyStimulus(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0, 8, 1'b0, -1);
        applyStimulus(48'hA0A1A2A3A4A5, 48'hB0B1B2B3B4B5, 16'h86DD, 1'b0, 16'h0, 23, 1'b0, -1);
        drainAndCount();
        ready_mode = 0;

`ifdef VLAN_INSERT_EN
        $display("[TB] T4: VLAN tag insertion");
        applyStimulus(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b1, 16'h0064, 2, 1'b0, -1);
        applyStimulus(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b1, 16'hE123, 15, 1'b0, -1);
        drainAndCount();
`endif

        $display("[TB] T5: reset mid-payload then a clean frame");
        applyStimulus(48'h0C0D0E0F1011, 48'h121314151617, 16'h0806, 1'b0, 16'h0, 30, 1'b0, 2);
        doReset();
        applyStimulus(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0, 1, 1'b1, -1);
        drainAndCount();

        $display("[TB] T6: ten back-to-back frames");
        doReset();
        for (int n = 1; n <= 10; n++)
            applyStimulus(48'h020000000000 + 48'(n), 48'h0A0B0C0D0E0F, 16'h0800, 1'b0, 16'h0, n, 1'b0, -1);
        drainAndCount();

        $display("[TB] T7: random frames with random backpressure");
        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            d = {16'($urandom), $urandom};
            s = {16'($urandom), $urandom};
`ifdef VLAN_INSERT_EN
            v = 1'($urandom_range(0, 1));
`else
            v = 1'b0;
`endif
            applyStimulus(d, s, 16'($urandom), v, 16'($urandom), $urandom_range(1, 40), 1'b0, -1);
        end
        drainAndCount();
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
